// File: rtl/mont_const_gen.sv
// Montgomery constant generator: R_r = 2^N mod M and R_t = 2^(2N) mod M
// by iterated modular doubling, S doublings per clock.
module mont_const_gen #(
    parameter int unsigned N           = 1024,
    parameter int unsigned S           = 1,
    parameter int unsigned REQUIRE_ODD = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] M,
    output logic [N-1:0] R_r,
    output logic [N-1:0] R_t,
    output logic         busy,
    output logic         done,
    output logic         err
);

    localparam int unsigned CW = $clog2(2 * N + 1);
    localparam logic [CW-1:0] CntR = CW'(N);
    localparam logic [CW-1:0] CntT = CW'(2 * N);
    localparam logic [CW-1:0] CntStep = CW'(S);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StFin
    } state_e;

    state_e        state_q;
    logic [N-1:0]  m_q;
    logic [N-1:0]  x_q;
    logic [N-1:0]  x_nxt;
    logic [N:0]    dbl_t;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_nxt;
    logic          m_bad;
    logic          m_one;

    // x_q < m_q always holds, so one conditional subtract per doubling suffices.
    always_comb begin
        dbl_t = '0;
        x_nxt = x_q;
        for (int i = 0; i < int'(S); i++) begin
            dbl_t = {x_nxt, 1'b0};
            if (dbl_t >= {1'b0, m_q}) begin
                dbl_t = dbl_t - {1'b0, m_q};
            end
            x_nxt = dbl_t[N-1:0];
        end
    end

    always_comb begin
        cnt_nxt = cnt_q + CntStep;
        m_one   = (M == {{(N-1){1'b0}}, 1'b1});
        m_bad   = (M == '0) || ((REQUIRE_ODD != 0) && !M[0]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            m_q     <= '0;
            x_q     <= '0;
            cnt_q   <= '0;
            R_r     <= '0;
            R_t     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    done <= 1'b0;
                    busy <= 1'b0;
                    if (start) begin
                        m_q <= M;
                        err <= 1'b0;
                        if (m_bad) begin
                            // Rejected modulus: report immediately through FIN.
                            R_r     <= '0;
                            R_t     <= '0;
                            err     <= 1'b1;
                            done    <= 1'b1;
                            state_q <= StFin;
                        end else begin
                            x_q     <= m_one ? '0 : {{(N-1){1'b0}}, 1'b1};
                            cnt_q   <= '0;
                            busy    <= 1'b1;
                            state_q <= StRun;
                        end
                    end
                end
                StRun: begin
                    x_q   <= x_nxt;
                    cnt_q <= cnt_nxt;
                    if (cnt_nxt == CntR) begin
                        R_r <= x_nxt;
                    end
                    if (cnt_nxt == CntT) begin
                        R_t     <= x_nxt;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state_q <= StFin;
                    end
                end
                StFin: begin
                    done    <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/mont_const_gen.md
Name: mont_const_gen

Overview:
- Parametrised generator of the Montgomery constants for modulus M: R_r = 2^N mod M and R_t = 2^(2N) mod M, with R = 2^N.
- Sits ahead of the Montgomery multiplier in the RSA decryption datapath. Runs once per key load.
- Generalises the fixed 1024-bit constant block:
  - width N is a parameter;
  - throughput is configurable (doublings per cycle);
  - has a modulus-validity check, busy/err status, a one-cycle done pulse and asynchronous reset.
- Uses iterated modular doubling, so no 2N-bit multiplier is needed.

Parameters:
- N, 1024, modulus/result width in bits; 8 or more.
- S, 1, modular doubling steps per clock. Must be 1, 2 or 4, and must divide N.
- REQUIRE_ODD, 1, when 1 an even modulus is rejected with err.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- M  input  N  modulus; captured on the accepted start edge
- R_r  output  N  2^N mod M (registered)
- R_t  output  N  2^(2N) mod M (registered)
- busy  output  1  high while a computation is in progress
- done  output  1  one-cycle completion pulse
- err  output  1  modulus-rejected flag, valid while done=1, held until next accepted start

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, x=0, cnt=0, m_q=0. R_r=0, R_t=0, busy=0, done=0, err=0.
- Reset mid-run aborts immediately; no done is produced.
- Internal registers:
  - m_q (N bits), captured M.
  - x (N bits), running value, invariant x < m_q.
  - cnt, width clog2(2N+1), counts doublings performed.
- One doubling step: t = {x,1'b0} (N+1 bits); x' = (t >= m_q) ? t - m_q : t. Exactly one conditional subtract is needed because x < m_q.
- S steps are chained combinationally per clock.
- States: IDLE, RUN, FIN.
- IDLE:
  - done=0, busy=0.
  - On start=1: m_q<=M, err<=0, busy<=1.
  - Invalid modulus means M==0, or REQUIRE_ODD=1 and M[0]==0. If invalid: R_r<=0, R_t<=0, err<=1, go to FIN.
  - Otherwise: x <= (M==1) ? 0 : 1, cnt<=0, go to RUN.
- RUN:
  - Each edge: x <= S chained doublings of x; cnt <= cnt+S.
  - When cnt+S == N: R_r <= new x in the same edge.
  - When cnt+S == 2N: R_t <= new x, done<=1, busy<=0, go to FIN.
- FIN:
  - done is high for exactly this one cycle; next edge sets done<=0 and returns to IDLE.
  - An invalid-M path enters FIN with done<=1 set on the accept edge, busy<=0.
- Latency, valid M: start accepted at edge E0; done=1 during the cycle after edge E(2N/S).
  - S=1 gives 2N RUN edges.
  - R_r is stable from edge E(N/S) onward.
- Latency, invalid M: done=1 in the cycle after E0, with err=1.
- Handshake:
  - start while busy=1 or in FIN is ignored, not queued; M changes while busy are ignored.
  - start held high continuously restarts on each IDLE cycle. That means back-to-back runs with one idle cycle between done and the next accept.
- Outputs R_r, R_t and err hold their last values until the next accepted start.
  - R_r updates mid-run, so consumers read both outputs only on done.
- M==1 yields R_r=0, R_t=0, err=0.
- No arithmetic wider than N+1 bits is used anywhere.

Test Plan:
- N=8, S=1, M=0xB5, one start pulse:
  - done high 16 cycles after the accept edge, err=0;
  - R_r=0x4B (75), R_t=0x0E (14);
  - busy high for exactly 16 cycles.
- N=8, S=1, M=0xFF: R_r=0x01, R_t=0x01.
- N=8, M=0x01: R_r=0x00, R_t=0x00, err=0, normal 16-cycle latency.
- N=8, REQUIRE_ODD=1:
  - M=0x80: done in the cycle after accept, err=1, R_r=R_t=0.
  - M=0x00: same response.
  - Repeat M=0x80 with REQUIRE_ODD=0: R_r=0x00, R_t=0x00, err=0.
- N=32, S=4, M=0xFFFFFFFB: done 16 cycles after accept, R_r=0x00000005, R_t=0x00000019.
  - Repeat with S=1: identical results, 64-cycle latency.
- N=8, M=0xB5 then:
  - pulse start again at cycle 5 with M=0x07: ignored, result still 0x4B/0x0E;
  - assert rst_n=0 at cycle 8 of a new run: all outputs 0 immediately, no done;
  - after release, start with M=0xB5: correct result.
